// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch lap controller: state encoding and a
// constant-evaluable log2 helper used to size selector and counter widths.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED   = 2'd0,
        COUNTING = 2'd1,
        IDLE     = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_lap_ctl_if.sv
// Button/readout bus of the stopwatch lap controller; the controller
// takes the slave side, the button debouncer and display logic the master side.
interface stopwatch_lap_ctl_if #(
    parameter int TIME_W    = 16,
    parameter int LAP_DEPTH = 4
);
    localparam int SEL_W = stopwatch_pkg::clog2(LAP_DEPTH);

    // trig/split are one-cycle strobes acting as valid with an always-high
    // ready: each cycle they are high is consumed at that posedge, no stalling.
    logic                      trig;
    logic                      split;
    logic [SEL_W-1:0]          lap_sel;
    logic                      init_regs;
    logic                      count_enabled;
    logic [TIME_W-1:0]         elapsed;
    logic                      time_ovf;
    logic [SEL_W:0]            lap_count;
    logic [TIME_W-1:0]         lap_data;
    logic                      lap_ovf;
    stopwatch_pkg::state_t     dbg_state;

    modport slave (
        input  trig, split, lap_sel,
        output init_regs, count_enabled, elapsed, time_ovf,
               lap_count, lap_data, lap_ovf, dbg_state
    );

    modport master (
        output trig, split, lap_sel,
        input  init_regs, count_enabled, elapsed, time_ovf,
               lap_count, lap_data, lap_ovf, dbg_state
    );

endinterface

// File: rtl/stopwatch_lap_buf.sv
// Lap storage: fixed-depth array filled in order, sticky overflow on a
// write when full, and a registered readout that returns 0 for empty slots.
module stopwatch_lap_buf
    import stopwatch_pkg::*;
#(
    parameter int TIME_W    = 16,
    parameter int LAP_DEPTH = 4,
    localparam int SEL_W    = clog2(LAP_DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [TIME_W-1:0] wr_data,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [TIME_W-1:0] rd_data,
    output logic [SEL_W:0]    count,
    output logic              ovf
);

    localparam logic [SEL_W:0] DEPTH_C = (SEL_W + 1)'(LAP_DEPTH);

    logic [TIME_W-1:0] mem_q [LAP_DEPTH];
    logic [SEL_W:0]    cnt_q;
    logic              ovf_q;
    logic [TIME_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q <= '0;
            ovf_q <= 1'b0;
            rd_q  <= '0;
        end else begin
            if (wr_en) begin
                if (cnt_q < DEPTH_C) begin
                    mem_q[cnt_q[SEL_W-1:0]] <= wr_data;
                    cnt_q                   <= cnt_q + 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
            // Slots at or beyond the fill level read as zero, not stale data.
            rd_q <= ({1'b0, rd_sel} < cnt_q) ? mem_q[rd_sel] : '0;
        end
    end

    assign rd_data = rd_q;
    assign count   = cnt_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/stopwatch_lap_ctl.sv
// Stopwatch control: IDLE/COUNTING/PAUSED FSM, tick prescaler and saturating
// elapsed counter feeding a lap buffer. STOPWATCH_LAP_DELTA_EN stores lap deltas.
module stopwatch_lap_ctl
    import stopwatch_pkg::*;
#(
    parameter int TIME_W    = 16,
    parameter int LAP_DEPTH = 4,
    parameter int TICK_DIV  = 10
) (
    input logic                clk,
    input logic                reset,
    stopwatch_lap_ctl_if.slave bus
);

    localparam int                 SEL_W    = clog2(LAP_DEPTH);
    localparam int                 DIV_W    = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0]  TIME_MAX = '1;
    localparam logic [SEL_W:0]     DEPTH_C  = (SEL_W + 1)'(LAP_DEPTH);

    state_t            state_q, state_d;
    logic              init_regs;
    logic              count_en;
    logic              lap_wr;
    logic              tick;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TIME_W-1:0] elapsed_q, elapsed_d;
    logic              time_ovf_q, time_ovf_d;
    logic [TIME_W-1:0] lap_wr_data;
    logic              lap_full;

    always_comb begin
        state_d   = state_q;
        init_regs = 1'b0;
        count_en  = 1'b0;
        lap_wr    = 1'b0;
        if (reset) begin
            init_regs = 1'b1;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.trig) begin
                        state_d  = COUNTING;
                        count_en = 1'b1;
                    end else begin
                        init_regs = 1'b1;
                    end
                end
                COUNTING: begin
                    // A pause request outranks a simultaneous lap capture.
                    if (bus.trig) begin
                        state_d = PAUSED;
                    end else begin
                        count_en = 1'b1;
                        lap_wr   = bus.split;
                    end
                end
                PAUSED: begin
                    if (bus.trig) begin
                        state_d  = COUNTING;
                        count_en = 1'b1;
                    end else if (bus.split) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        div_d      = div_q;
        tick       = 1'b0;
        elapsed_d  = elapsed_q;
        time_ovf_d = time_ovf_q;
        if (init_regs) begin
            div_d      = '0;
            elapsed_d  = '0;
            time_ovf_d = 1'b0;
        end else if (count_en) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        if (tick) begin
            if (elapsed_q == TIME_MAX) begin
                time_ovf_d = 1'b1;
            end else begin
                elapsed_d = elapsed_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            elapsed_q  <= '0;
            time_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            elapsed_q  <= elapsed_d;
            time_ovf_q <= time_ovf_d;
        end
    end

    assign lap_full = (bus.lap_count == DEPTH_C);

`ifdef STOPWATCH_LAP_DELTA_EN
    logic [TIME_W-1:0] last_lap_q, last_lap_d;

    // Only accepted captures move the reference; dropped ones leave it alone.
    always_comb begin
        last_lap_d = last_lap_q;
        if (init_regs) begin
            last_lap_d = '0;
        end else if (lap_wr && !lap_full) begin
            last_lap_d = elapsed_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_lap_q <= '0;
        end else begin
            last_lap_q <= last_lap_d;
        end
    end

    assign lap_wr_data = elapsed_q - last_lap_q;
`else
    assign lap_wr_data = elapsed_q;
`endif

    stopwatch_lap_buf #(
        .TIME_W    (TIME_W),
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_buf (
        .clk     (clk),
        .clr     (init_regs),
        .wr_en   (lap_wr),
        .wr_data (lap_wr_data),
        .rd_sel  (bus.lap_sel),
        .rd_data (bus.lap_data),
        .count   (bus.lap_count),
        .ovf     (bus.lap_ovf)
    );

    assign bus.init_regs     = init_regs;
    assign bus.count_enabled = count_en;
    assign bus.elapsed       = elapsed_q;
    assign bus.time_ovf      = time_ovf_q;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_stopwatch_lap_ctl.sv
// Directed bench for stopwatch_lap_ctl: three instances cover TICK_DIV=1,
// TICK_DIV=3 and a 4-bit counter; lap expectations follow STOPWATCH_LAP_DELTA_EN.
module tb_stopwatch_lap_ctl;
    import stopwatch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    stopwatch_lap_ctl_if #(.TIME_W(16), .LAP_DEPTH(4)) if_a ();
    stopwatch_lap_ctl_if #(.TIME_W(16), .LAP_DEPTH(4)) if_b ();
    stopwatch_lap_ctl_if #(.TIME_W(4),  .LAP_DEPTH(4)) if_c ();

    stopwatch_lap_ctl #(.TIME_W(16), .LAP_DEPTH(4), .TICK_DIV(1)) dut_a (
        .clk(clk), .reset(rst_a), .bus(if_a.slave));
    stopwatch_lap_ctl #(.TIME_W(16), .LAP_DEPTH(4), .TICK_DIV(3)) dut_b (
        .clk(clk), .reset(rst_b), .bus(if_b.slave));
    stopwatch_lap_ctl #(.TIME_W(4),  .LAP_DEPTH(4), .TICK_DIV(1)) dut_c (
        .clk(clk), .reset(rst_c), .bus(if_c.slave));

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    // 0 = idle cycle, 1 = trig pulse, 2 = split pulse
    int seq_full [10] = '{1, 0, 2, 0, 0, 2, 2, 0, 2, 2};
    int seq_two  [8]  = '{1, 0, 0, 2, 0, 0, 0, 2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input int op);
        if_a.trig  = (op == 1);
        if_a.split = (op == 2);
        tick();
        if_a.trig  = 1'b0;
        if_a.split = 1'b0;
    endtask

    task automatic read_laps_a(input int n);
        for (int k = 0; k < n; k++) begin
            if_a.lap_sel = 2'(k);
            tick();
            check("lap_readout", 32'(if_a.lap_data), 32'(exp_q.pop_front()));
        end
        if_a.lap_sel = 2'd0;
    endtask

    initial begin
        {if_a.trig, if_a.split, if_a.lap_sel} = '0;
        {if_b.trig, if_b.split, if_b.lap_sel} = '0;
        {if_c.trig, if_c.split, if_c.lap_sel} = '0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        // Reset then IDLE: clear request asserted, nothing advancing
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rst_init_regs", 32'(if_a.init_regs), 1);
            check("rst_count_en", 32'(if_a.count_enabled), 0);
            tick();
            check("rst_elapsed", 32'(if_a.elapsed), 0);
            check("rst_lap_count", 32'(if_a.lap_count), 0);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_init_regs", 32'(if_a.init_regs), 1);
            check("idle_count_en", 32'(if_a.count_enabled), 0);
            tick();
            check("idle_elapsed", 32'(if_a.elapsed), 0);
            check("idle_state", 32'(if_a.dbg_state), 32'(IDLE));
        end

        // Count and lap with TICK_DIV=1
        if_a.trig = 1'b1;
        #1;
        check("start_count_en", 32'(if_a.count_enabled), 1);
        check("start_init_regs", 32'(if_a.init_regs), 0);
        tick();
        if_a.trig = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("run_count_en", 32'(if_a.count_enabled), 1);
            tick();
        end
        if_a.split = 1'b1;
        #1;
        check("split_count_en", 32'(if_a.count_enabled), 1);
        tick();
        if_a.split = 1'b0;
        check("lap1_elapsed", 32'(if_a.elapsed), 6);
        check("lap1_count", 32'(if_a.lap_count), 1);
        if_a.lap_sel = 2'd0;
        tick();
        check("lap1_data", 32'(if_a.lap_data), 5);
        if_a.lap_sel = 2'd1;
        tick();
        check("empty_slot_data", 32'(if_a.lap_data), 0);
        if_a.lap_sel = 2'd0;

        // trig and split together in COUNTING: pause, no capture
        if_a.trig = 1'b1;
        if_a.split = 1'b1;
        #1;
        check("both_count_en", 32'(if_a.count_enabled), 0);
        check("both_init_regs", 32'(if_a.init_regs), 0);
        tick();
        if_a.trig = 1'b0;
        check("both_state", 32'(if_a.dbg_state), 32'(PAUSED));
        check("both_lap_count", 32'(if_a.lap_count), 1);
        check("both_elapsed", 32'(if_a.elapsed), 8);
        #1;
        check("clr_req_outputs", {30'd0, if_a.init_regs, if_a.count_enabled}, 0);
        tick();
        if_a.split = 1'b0;
        check("clr_state", 32'(if_a.dbg_state), 32'(IDLE));
        check("clr_elapsed_held", 32'(if_a.elapsed), 8);
        #1;
        check("clr_init_regs", 32'(if_a.init_regs), 1);
        tick();
        check("clr_elapsed", 32'(if_a.elapsed), 0);
        check("clr_lap_count", 32'(if_a.lap_count), 0);

        // Fill the buffer, then one more split
        for (int i = 0; i < 10; i++) run_a(seq_full[i]);
        check("full_lap_count", 32'(if_a.lap_count), 4);
        check("full_lap_ovf", 32'(if_a.lap_ovf), 1);
        check("full_elapsed", 32'(if_a.elapsed), 10);
`ifdef STOPWATCH_LAP_DELTA_EN
        exp_q.push_back(16'd2); exp_q.push_back(16'd3);
        exp_q.push_back(16'd1); exp_q.push_back(16'd2);
`else
        exp_q.push_back(16'd2); exp_q.push_back(16'd5);
        exp_q.push_back(16'd6); exp_q.push_back(16'd8);
`endif
        read_laps_a(4);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("midrst_lap_ovf", 32'(if_a.lap_ovf), 0);
        check("midrst_time_ovf", 32'(if_a.time_ovf), 0);
        check("midrst_elapsed", 32'(if_a.elapsed), 0);
        check("midrst_lap_count", 32'(if_a.lap_count), 0);

        // Laps at elapsed 3 and 7
        for (int i = 0; i < 8; i++) run_a(seq_two[i]);
        check("two_lap_count", 32'(if_a.lap_count), 2);
        exp_q.push_back(16'd3);
`ifdef STOPWATCH_LAP_DELTA_EN
        exp_q.push_back(16'd4);
`else
        exp_q.push_back(16'd7);
`endif
        read_laps_a(2);

        // Pause retention with TICK_DIV=3
        if_b.trig = 1'b1;
        #1;
        check("b_start_count_en", 32'(if_b.count_enabled), 1);
        tick();
        if_b.trig = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("b_run_elapsed", 32'(if_b.elapsed), 1);
        if_b.trig = 1'b1;
        #1;
        check("b_pause_count_en", 32'(if_b.count_enabled), 0);
        tick();
        if_b.trig = 1'b0;
        check("b_pause_state", 32'(if_b.dbg_state), 32'(PAUSED));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("b_pause_elapsed", 32'(if_b.elapsed), 1);
        end
        if_b.trig = 1'b1;
        tick();
        if_b.trig = 1'b0;
        check("b_resume_state", 32'(if_b.dbg_state), 32'(COUNTING));
        check("b_resume1_elapsed", 32'(if_b.elapsed), 1);
        tick();
        check("b_resume2_elapsed", 32'(if_b.elapsed), 2);

        // Saturation of a 4-bit counter
        if_c.trig = 1'b1;
        tick();
        if_c.trig = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("c_at_max_elapsed", 32'(if_c.elapsed), 15);
        check("c_at_max_ovf", 32'(if_c.time_ovf), 0);
        for (int i = 0; i < 5; i++) tick();
        check("c_sat_elapsed", 32'(if_c.elapsed), 15);
        check("c_sat_ovf", 32'(if_c.time_ovf), 1);
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        check("c_rst_ovf", 32'(if_c.time_ovf), 0);
        check("c_rst_elapsed", 32'(if_c.elapsed), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap_ctl.md
Name: stopwatch_lap_ctl

Overview:
- Second-generation stopwatch controller.
- Keeps the IDLE/COUNTING/PAUSED control FSM and the Mealy init_regs/count_enabled outputs of the current control block.
- Adds an internal tick prescaler, a parametrised-width elapsed-time counter and a parametrised-depth lap buffer.
- Sits between the debounced button pulses and the display/readout logic.

Parameters:
- TIME_W, 16, width of the elapsed-time counter and of each lap entry.
- LAP_DEPTH, 4, number of lap slots; power of 2, range 2 to 16.
- TICK_DIV, 10, clk cycles per time tick; minimum 1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; forces IDLE and clears everything.
- trig  in  1  start/pause pulse, one cycle wide.
- split  in  1  lap capture (COUNTING) or clear (PAUSED) pulse, one cycle wide.
- lap_sel  in  log2(LAP_DEPTH)  lap readout index.
- init_regs  out  1  Mealy: clear request to downstream registers.
- count_enabled  out  1  Mealy: time advancing this cycle.
- elapsed  out  TIME_W  registered tick count.
- time_ovf  out  1  sticky: elapsed saturated.
- lap_count  out  log2(LAP_DEPTH)+1  number of stored laps.
- lap_data  out  TIME_W  registered readout of lap[lap_sel].
- lap_ovf  out  1  sticky: a split arrived while the buffer was full.

Behaviour:
- State encoding: IDLE=2, COUNTING=1, PAUSED=0. Reset state is IDLE.
- reset has priority over all other inputs. While reset=1: init_regs=1, count_enabled=0; at posedge, state goes to IDLE.
- IDLE:
  - trig=1: go to COUNTING; outputs {init_regs,count_enabled}=01.
  - trig=0: stay in IDLE; outputs 10.
- COUNTING:
  - trig=1: go to PAUSED; outputs 00. trig wins over split in the same cycle; no lap is captured.
  - trig=0: outputs 01. If split=1, capture a lap and stay in COUNTING.
- PAUSED:
  - trig=1: go to COUNTING; outputs 01.
  - split=1 (trig=0): go to IDLE; outputs 00. Clearing happens on the following IDLE cycles via init_regs.
  - otherwise: stay in PAUSED; outputs 00.
- Clearing: at any posedge with init_regs=1, the prescaler, elapsed, time_ovf, lap_count, lap_ovf, lap_data and all lap slots are cleared to 0.
- Prescaler:
  - div_cnt increments on cycles where count_enabled=1.
  - When div_cnt==TICK_DIV-1: div_cnt wraps to 0 and elapsed increments.
  - div_cnt holds while paused, so the fractional tick is preserved across a pause.
- elapsed saturates at 2^TIME_W-1. An increment attempted at the maximum sets time_ovf; it never wraps.
- Lap capture (COUNTING, split=1, trig=0):
  - If lap_count<LAP_DEPTH: lap[lap_count] gets the elapsed value held before that cycle's increment, and lap_count increments.
  - If lap_count==LAP_DEPTH: the capture is dropped and lap_ovf is set.
- Readout: lap_data is registered with one-cycle latency from lap_sel. lap_sel>=lap_count reads 0.
- Reset outputs: all registered outputs are 0. init_regs=1, count_enabled=0.

Optional Feature:
- Macro: STOPWATCH_LAP_DELTA_EN.
- Defined:
  - Each lap stores elapsed minus the previously captured absolute value; the first lap stores its absolute value.
  - Adds an internal TIME_W-bit last_lap register, cleared by init_regs.
  - Underflow is impossible because elapsed is monotonic.
- Undefined: laps store absolute elapsed values and there is no last_lap register.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding constants (IDLE, COUNTING, PAUSED) and the 2-bit state type;
  - a clog2 helper function.
- Sub-module stopwatch_lap_buf holds the lap array, write pointer, full/ovf logic and registered readout. Its inputs are clk, clr, wr_en, wr_data and rd_sel.
- The top level holds the FSM, prescaler and elapsed counter.

Test Plan:
1. Reset and IDLE (TICK_DIV=1). Sequence: reset=1 for 2 cycles, then 3 idle cycles. Require init_regs=1, count_enabled=0, elapsed=0, lap_count=0 throughout.
2. Count and lap (TICK_DIV=1). Sequence: trig pulse, 4 idle cycles, split pulse. Require count_enabled=1 on 6 cycles. After the split: lap[0]=5, elapsed=6, lap_count=1, and lap_data=5 one cycle after lap_sel=0.
3. Pause retention (TICK_DIV=3). Sequence: trig, count 4 cycles, trig, wait 10 cycles, trig, 2 cycles. Require:
   - elapsed=1 and stable during the pause;
   - elapsed=2 after resume, because div_cnt resumed from 1.
4. Simultaneous inputs. In COUNTING, drive trig=1 with split=1: state goes to PAUSED and lap_count is unchanged. In PAUSED, drive split=1: state goes to IDLE, and the next cycle shows elapsed=0 and lap_count=0.
5. Buffer full (LAP_DEPTH=4). Apply 5 splits in COUNTING. Require lap_count=4 and lap_ovf=1; slots 0–3 hold their original values. Reset mid-count clears lap_ovf, time_ovf and elapsed on the next cycle.
6. Saturation and delta mode.
   - TIME_W=4, TICK_DIV=1, count 20 cycles: require elapsed=15 and time_ovf=1.
   - With STOPWATCH_LAP_DELTA_EN, laps at elapsed 3 and 7: require lap[0]=3, lap[1]=4.
